// File: rtl/direct_interc_pipe.sv
// Elastic valid/ready pipeline for long direct tile-to-tile connections.
// DEPTH register stages with bubble collapsing; DEPTH=0 degenerates to a plain wire.
module direct_interc_pipe #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] occupancy
);

  if (DEPTH > 8) begin : g_bad_depth
    $error("direct_interc_pipe: DEPTH must be in 0..8");
  end

  if ((64'd1 << CNT_W) <= 64'(DEPTH)) begin : g_bad_cnt_w
    $error("direct_interc_pipe: CNT_W too narrow to count DEPTH stages");
  end

  if (DEPTH == 0) begin : g_wire
    assign out       = in;
    assign out_valid = in_valid;
    assign in_ready  = out_ready;
    assign occupancy = '0;

    // Clock, reset and flush are meaningless for a bare wire.
    logic unused_pins;
    assign unused_pins = &{1'b0, clk, rst_n, flush};
  end else begin : g_pipe
    logic [DEPTH-1:0]            v_q;
    logic [DEPTH-1:0]            v_d;
    logic [DEPTH-1:0][WIDTH-1:0] d_q;
    logic [DEPTH-1:0]            up_v;
    logic [DEPTH-1:0][WIDTH-1:0] up_d;
    logic [DEPTH-1:0]            ld;
    logic [DEPTH:0]              rdy;
    logic [CNT_W-1:0]            occ_q;
    logic [CNT_W-1:0]            occ_d;

    // Ready ripples back from out_ready; each stage also takes its upstream neighbour.
    always_comb begin
      rdy   = '0;
      up_v  = '0;
      up_d  = '0;
      ld    = '0;
      v_d   = v_q;
      occ_d = '0;

      rdy[DEPTH] = out_ready;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
        rdy[i] = ~v_q[i] | rdy[i+1];
      end

      up_v[0] = in_valid;
      up_d[0] = in;
      for (int i = 1; i < int'(DEPTH); i++) begin
        up_v[i] = v_q[i-1];
        up_d[i] = d_q[i-1];
      end

      for (int i = 0; i < int'(DEPTH); i++) begin
        if (flush) begin
          v_d[i] = 1'b0;
        end else if (rdy[i]) begin
          v_d[i] = up_v[i];
        end
        // Bubbles never overwrite data, keeping out stable during a stall.
        ld[i] = rdy[i] & up_v[i] & ~flush;
        occ_d = occ_d + CNT_W'(v_d[i]);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= '0;
        d_q   <= '0;
        occ_q <= '0;
      end else begin
        v_q   <= v_d;
        occ_q <= occ_d;
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (ld[i]) begin
            d_q[i] <= up_d[i];
          end
        end
      end
    end

    assign in_ready  = rdy[0] & ~flush;
    assign out       = d_q[DEPTH-1];
    assign out_valid = v_q[DEPTH-1];
    assign occupancy = occ_q;
  end

endmodule

// File: tb/tb_direct_interc_pipe.sv
// Bench for direct_interc_pipe: DEPTH=2 and DEPTH=3 pipes against a slot-window model,
// plus a DEPTH=0 pass-through instance.
`timescale 1ns/1ps
module tb_direct_interc_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] din  [2];
  logic       ivl  [2];
  logic       ord  [2];
  logic       fl   [2];
  logic [7:0] dout [2];
  logic       ovl  [2];
  logic       irdy [2];
  logic [3:0] occ  [2];

  logic [3:0] c_in, c_out, c_occ;
  logic       c_iv, c_or, c_ov, c_ir, c_fl;

  direct_interc_pipe #(.WIDTH(8), .DEPTH(2), .CNT_W(4)) u_d2 (
    .clk(clk), .rst_n(rst_n), .flush(fl[0]), .in(din[0]), .in_valid(ivl[0]),
    .in_ready(irdy[0]), .out(dout[0]), .out_valid(ovl[0]), .out_ready(ord[0]),
    .occupancy(occ[0]));

  direct_interc_pipe #(.WIDTH(8), .DEPTH(3), .CNT_W(4)) u_d3 (
    .clk(clk), .rst_n(rst_n), .flush(fl[1]), .in(din[1]), .in_valid(ivl[1]),
    .in_ready(irdy[1]), .out(dout[1]), .out_valid(ovl[1]), .out_ready(ord[1]),
    .occupancy(occ[1]));

  direct_interc_pipe #(.WIDTH(4), .DEPTH(0), .CNT_W(4)) u_d0 (
    .clk(clk), .rst_n(rst_n), .flush(c_fl), .in(c_in), .in_valid(c_iv),
    .in_ready(c_ir), .out(c_out), .out_valid(c_ov), .out_ready(c_or),
    .occupancy(c_occ));

  int nvec = 0;
  int nerr = 0;

  int  p_valid [2];
  int  p_ready [2];
  bit  flush_req [2];
  bit  c_rand = 1'b1;

  logic [7:0] src  [2][$];
  logic [7:0] sent [2][$];
  logic [7:0] rx_d [2][$];
  int         rx_e [2][$];

  // Model: per-slot valid and word, slot 0 nearest the input.
  bit         mv [2][8];
  logic [7:0] md [2][8];
  int         cyc = 0;
  int         first_acc [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int dep(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic int mocc(input int k);
    int n = 0;
    for (int i = 0; i < dep(k); i++) n += int'(mv[k][i]);
    return n;
  endfunction

  // Input side can accept iff not flushing and the output drains or some slot is empty.
  function automatic bit m_in_ready(input int k);
    if (fl[k]) return 1'b0;
    if (ord[k]) return 1'b1;
    for (int i = 0; i < dep(k); i++) if (!mv[k][i]) return 1'b0 == mv[k][i];
    return 1'b0;
  endfunction

  // Slots below the highest hole (or all, if the output drains) advance by one.
  task automatic model_edge(input int k);
    int d;
    int m;
    d = dep(k);
    m = 0;
    if (fl[k]) begin
      for (int i = 0; i < d; i++) mv[k][i] = 1'b0;
      return;
    end
    if (ord[k]) m = d;
    else for (int i = 0; i < d; i++) if (!mv[k][i]) m = i + 1;
    for (int i = m - 1; i >= 1; i--) begin
      mv[k][i] = mv[k][i-1];
      if (mv[k][i-1]) md[k][i] = md[k][i-1];
    end
    if (m > 0) begin
      mv[k][0] = ivl[k];
      if (ivl[k]) begin
        md[k][0] = din[k];
        sent[k].push_back(din[k]);
        if (first_acc[k] < 0) first_acc[k] = cyc;
        void'(src[k].pop_front());
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 8; i++) mv[k][i] = 1'b0;
    end else begin
      cyc++;
      for (int k = 0; k < 2; k++) model_edge(k);
    end
  end

  // Stimulus driver.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      ivl[k] = (src[k].size() > 0) && (int'($urandom_range(99)) < p_valid[k]);
      din[k] = ivl[k] ? src[k][0] : 8'($urandom);
      ord[k] = int'($urandom_range(99)) < p_ready[k];
      fl[k]  = flush_req[k];
    end
    if (c_rand) begin
      c_in = 4'($urandom);
      c_iv = 1'($urandom);
      c_or = 1'($urandom);
      c_fl = 1'($urandom);
    end
  end

  // Per-cycle compare against the model, and delivery log.
  always @(negedge clk) begin
    #2;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("k%0d out_valid", k), 32'(ovl[k]), 32'(mv[k][dep(k)-1]));
      chk($sformatf("k%0d occupancy", k), 32'(occ[k]), 32'(mocc(k)));
      chk($sformatf("k%0d in_ready", k), 32'(irdy[k]), 32'(m_in_ready(k)));
      if (mv[k][dep(k)-1])
        chk($sformatf("k%0d out", k), 32'(dout[k]), 32'(md[k][dep(k)-1]));
      if (ovl[k] && ord[k]) begin
        rx_d[k].push_back(dout[k]);
        rx_e[k].push_back(cyc + 1);
      end
    end
    chk("d0 out", 32'(c_out), 32'(c_in));
    chk("d0 out_valid", 32'(c_ov), 32'(c_iv));
    chk("d0 in_ready", 32'(c_ir), 32'(c_or));
    chk("d0 occupancy", 32'(c_occ), 32'd0);
  end

  task automatic rx_clear(input int k);
    rx_d[k].delete();
    rx_e[k].delete();
    first_acc[k] = -1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int peak;
    int t;
    first_acc[0] = -1;
    first_acc[1] = -1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #3 rst_n = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset out_valid", 32'(ovl[k]), 32'd0);
      chk("reset occupancy", 32'(occ[k]), 32'd0);
      chk("reset out", 32'(dout[k]), 32'd0);
      chk("reset in_ready", 32'(irdy[k]), 32'd1);
    end

    // DEPTH=2, full-rate stream of three words.
    @(posedge clk); #1;
    rx_clear(0);
    src[0].push_back(8'h11); src[0].push_back(8'h22); src[0].push_back(8'h33);
    p_valid[0] = 100; p_ready[0] = 100;
    peak = 0;
    repeat (6) begin
      @(negedge clk); #3;
      if (int'(occ[0]) > peak) peak = int'(occ[0]);
    end
    chk("t1 count", 32'(rx_d[0].size()), 32'd3);
    for (int j = 0; j < 3; j++) begin
      chk("t1 word", 32'(rx_d[0][j]), 32'(8'(8'h11 * (j + 1))));
      chk("t1 latency", 32'(rx_e[0][j] - first_acc[0]), 32'(2 + j));
    end
    chk("t1 peak occupancy", 32'(peak), 32'd2);

    // DEPTH=3, stalled output fills the pipe then drains in order.
    @(posedge clk); #1;
    rx_clear(1);
    for (int j = 0; j < 5; j++) src[1].push_back(8'(8'hA0 + j));
    p_valid[1] = 100; p_ready[1] = 0;
    repeat (6) @(negedge clk);
    #3;
    chk("t2 occupancy full", 32'(occ[1]), 32'd3);
    chk("t2 in_ready low", 32'(irdy[1]), 32'd0);
    chk("t2 out_valid", 32'(ovl[1]), 32'd1);
    chk("t2 stalled out", 32'(dout[1]), 32'hA0);
    chk("t2 accepted", 32'(src[1].size()), 32'd2);
    @(posedge clk); #1;
    p_ready[1] = 100;
    repeat (10) @(negedge clk);
    #3;
    chk("t2 count", 32'(rx_d[1].size()), 32'd5);
    for (int j = 0; j < 5; j++) chk("t2 word", 32'(rx_d[1][j]), 32'(8'(8'hA0 + j)));
    for (int j = 1; j < 5; j++) chk("t2 no gap", 32'(rx_e[1][j] - rx_e[1][j-1]), 32'd1);

    // Random valid/ready on both pipes; scoreboard for loss, duplication and order.
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      rx_clear(k);
      sent[k].delete();
      for (int n = 0; n < 150; n++) src[k].push_back(8'($urandom));
      p_valid[k] = 50;
      p_ready[k] = 55;
    end
    for (t = 0; t < 3000; t++) begin
      @(posedge clk);
      if (src[0].size() == 0 && src[1].size() == 0 && mocc(0) == 0 && mocc(1) == 0) break;
    end
    chk("t3 drained", 32'(t < 3000), 32'd1);
    @(negedge clk); #3;
    for (int k = 0; k < 2; k++) begin
      chk("t3 sent", 32'(sent[k].size()), 32'd150);
      chk("t3 received", 32'(rx_d[k].size()), 32'd150);
      for (int j = 0; j < 150; j++) chk("t3 order", 32'(rx_d[k][j]), 32'(sent[k][j]));
    end

    // DEPTH=3 flush of a full pipe while 0x5A is offered.
    @(posedge clk); #1;
    p_valid[1] = 100; p_ready[1] = 0;
    src[1].push_back(8'h01); src[1].push_back(8'h02); src[1].push_back(8'h03);
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    chk("t4 full", 32'(occ[1]), 32'd3);
    src[1].push_back(8'h5A);
    flush_req[1] = 1'b1;
    rx_clear(1);
    @(negedge clk); #3;
    chk("t4 in_ready during flush", 32'(irdy[1]), 32'd0);
    @(posedge clk); #1;
    flush_req[1] = 1'b0;
    src[1].delete();
    chk("t4 occupancy", 32'(occ[1]), 32'd0);
    chk("t4 out_valid", 32'(ovl[1]), 32'd0);
    p_ready[1] = 100;
    repeat (5) @(negedge clk);
    #3;
    chk("t4 nothing out", 32'(rx_d[1].size()), 32'd0);

    // Asynchronous reset of a full pipe mid-cycle.
    @(posedge clk); #1;
    rx_clear(1);
    p_valid[1] = 100; p_ready[1] = 0;
    src[1].push_back(8'h01); src[1].push_back(8'h02); src[1].push_back(8'h03);
    repeat (5) @(negedge clk);
    #3;
    chk("t5 full", 32'(occ[1]), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("t5 out_valid", 32'(ovl[1]), 32'd0);
    chk("t5 occupancy", 32'(occ[1]), 32'd0);
    chk("t5 d2 out_valid", 32'(ovl[0]), 32'd0);
    @(negedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    p_ready[1] = 100;
    repeat (6) @(negedge clk);
    #3;
    chk("t5 nothing out", 32'(rx_d[1].size()), 32'd0);
    chk("t5 out_valid after", 32'(ovl[1]), 32'd0);

    // DEPTH=0 pass-through.
    @(posedge clk); #1;
    c_rand = 1'b0;
    c_in = 4'h9; c_iv = 1'b1; c_or = 1'b1; c_fl = 1'b1;
    #1;
    chk("t6 out", 32'(c_out), 32'h9);
    chk("t6 out_valid", 32'(c_ov), 32'd1);
    chk("t6 in_ready hi", 32'(c_ir), 32'd1);
    chk("t6 occupancy", 32'(c_occ), 32'd0);
    c_or = 1'b0;
    #1;
    chk("t6 in_ready lo", 32'(c_ir), 32'd0);
    chk("t6 out hold", 32'(c_out), 32'h9);
    repeat (4) @(negedge clk);
    #3;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/direct_interc_pipe.md
Name: direct_interc_pipe

Overview:
- Parametrised successor to the single-bit direct interconnect: carries a WIDTH-bit word from a routing source to a sink through DEPTH elastic register stages with valid/ready handshaking.
- Used where long direct connections between grid tiles need pipelining without losing throughput or dropping data under back-pressure.
- DEPTH=0 collapses to a pure combinational wire, identical in function to the plain direct connection.

Parameters:
- WIDTH, 1, data bits per transfer (1..64).
- DEPTH, 2, number of register stages (0..8); 0 means combinational pass-through.
- CNT_W, 4, width of the occupancy count output; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of all stages; takes effect at the next rising edge.
- in  input  WIDTH  upstream data.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  this block can accept a word this cycle.
- out  output  WIDTH  downstream data; taken from the last stage.
- out_valid  output  1  last stage holds a word.
- out_ready  input  1  downstream accepts a word this cycle.
- occupancy  output  CNT_W  number of stages currently holding valid words (0..DEPTH).

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low. Assertion immediately clears every stage valid bit. Deassertion is sampled on clk.
- Reset values: out_valid=0, occupancy=0, out=0 (data registers also cleared). in_ready=1 out of reset for DEPTH≥1.
- Transfer rule: a word moves on an edge when the sender's valid and the receiver's ready are both 1. Upstream accept = in_valid & in_ready. Downstream accept = out_valid & out_ready.
- Stage i (0 = input side, DEPTH-1 = output side) holds {v[i], d[i]}.
  - Stage i is ready when v[i]=0 or stage i+1 accepts this cycle. For the last stage, that means out_ready=1.
  - in_ready = ready of stage 0. It is combinational from out_ready through the chain; no combinational path from in_valid to in_ready.
- On each edge, stage i loads from stage i-1 (or from in for i=0) when stage i is ready. The new v[i] = v[i-1] (or in_valid). Otherwise the stage holds.
- Data registers load only when the incoming valid is 1. A bubble does not overwrite data, so out is stable while out_valid=1 and out_ready=0.
- Latency: DEPTH cycles from upstream accept to out_valid through an empty pipe. Throughput: 1 word/cycle when out_ready is held at 1.
- Bubbles collapse: a stalled output does not stall upstream until every stage is full.
- occupancy = popcount of v[]. It is registered alongside v and is always consistent with it.
- flush=1: at the edge, all v clear to 0 and occupancy becomes 0.
  - A word offered at the same edge is dropped, and in_ready is forced to 0 while flush=1.
  - A downstream accept during a flush cycle still counts as delivered.
- Simultaneous accept at both ends with a full pipe: legal. Occupancy stays DEPTH; words shift by one.
- Ordering: words exit in acceptance order. No duplication, no loss except on flush or reset.
- Reset mid-transfer: all in-flight words are discarded; no out_valid pulse after rst_n rises until a new word traverses DEPTH stages.
- DEPTH=0 (pass-through):
  - out=in, out_valid=in_valid, in_ready=out_ready, occupancy=0.
  - flush and clk have no effect; no registers are inferred.
- Widths: occupancy is zero-extended to CNT_W. Elaboration error if DEPTH>8 or 2^CNT_W ≤ DEPTH.

Test Plan:
- DEPTH=2, WIDTH=8, out_ready=1; send 0x11,0x22,0x33 on consecutive cycles -> out 0x11,0x22,0x33 on cycles 2,3,4 with out_valid contiguous; occupancy peaks at 2.
- DEPTH=3, out_ready=0, stream 0xA0..0xA4 -> in_ready drops after 3 accepts and occupancy=3. Then raise out_ready -> 0xA0,0xA1,0xA2,0xA3,0xA4 in order with no gaps; out is stable while stalled.
- DEPTH=2, alternate in_valid 1/0 with out_ready toggling pseudo-randomly -> scoreboard shows no loss, no duplicates, order preserved.
- DEPTH=3, full pipe, assert flush for one cycle while in_valid=1 with 0x5A -> next cycle occupancy=0, out_valid=0; 0x5A never appears at out.
- Full pipe holding 0x01..0x03, pull rst_n low asynchronously mid-cycle -> out_valid=0, occupancy=0 immediately; after release, no output until a new word is sent.
- DEPTH=0, WIDTH=4: drive in=0x9, in_valid=1, then toggle out_ready -> out=0x9 same cycle, in_ready mirrors out_ready combinationally, occupancy=0.
